// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong game controller and its surroundings:
// frame tick, button and score inputs, plus the score/state outputs.
interface pong_game_ctrl_if;
    logic       refresh_tick;
    logic       btn_start;
    logic       pts_1;
    logic       pts_2;
    logic       gra_still;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [1:0] winner;
    logic [1:0] game_state;

    modport master (
        output refresh_tick, btn_start, pts_1, pts_2,
        input  gra_still, score1, score2, winner, game_state
    );

    modport slave (
        input  refresh_tick, btn_start, pts_1, pts_2,
        output gra_still, score1, score2, winner, game_state
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game controller: new-game / play / new-ball / game-over sequencing,
// BCD scoring and frame-tick countdowns, all outputs registered.
module pong_game_ctrl #(
    parameter int WIN_SCORE     = 5,
    parameter int NEWBALL_TICKS = 120,
    parameter int OVER_TICKS    = 180
) (
    input logic             clk,
    input logic             reset,
    pong_game_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        NEWGAME = 2'b00,
        PLAY    = 2'b01,
        NEWBALL = 2'b10,
        OVER    = 2'b11
    } state_t;

    localparam logic [3:0] WinScore    = 4'(WIN_SCORE);
    localparam logic [7:0] NewballLoad = 8'(NEWBALL_TICKS);
    localparam logic [7:0] OverLoad    = 8'(OVER_TICKS);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [3:0] score1_q, score1_d;
    logic [3:0] score2_q, score2_d;
    logic [1:0] winner_q, winner_d;
    logic       graStill_q, graStill_d;
    logic       btnPrev_q;

    logic       startEdge;
    logic [3:0] score1Inc;
    logic [3:0] score2Inc;

    assign startEdge = bus.btn_start & ~btnPrev_q;
    assign score1Inc = score1_q + 4'd1;
    assign score2Inc = score2_q + 4'd1;

    // btnPrev resets high so a button held through reset is not taken as a start
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= NEWGAME;
            timer_q    <= 8'd0;
            score1_q   <= 4'd0;
            score2_q   <= 4'd0;
            winner_q   <= 2'b00;
            graStill_q <= 1'b1;
            btnPrev_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            score1_q   <= score1_d;
            score2_q   <= score2_d;
            winner_q   <= winner_d;
            graStill_q <= graStill_d;
            btnPrev_q  <= bus.btn_start;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = (bus.refresh_tick && (timer_q != 8'd0)) ? timer_q - 8'd1 : timer_q;
        score1_d = score1_q;
        score2_d = score2_q;
        winner_d = winner_q;

        unique case (state_q)
            NEWGAME: begin
                score1_d = 4'd0;
                score2_d = 4'd0;
                winner_d = 2'b00;
                if (startEdge) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                // A load here overrides any tick in the same cycle
                if (bus.pts_1) begin
                    score1_d = score1Inc;
                    if (score1Inc == WinScore) begin
                        state_d  = OVER;
                        winner_d = 2'b01;
                        timer_d  = OverLoad;
                    end else begin
                        state_d = NEWBALL;
                        timer_d = NewballLoad;
                    end
                end else if (bus.pts_2) begin
                    score2_d = score2Inc;
                    if (score2Inc == WinScore) begin
                        state_d  = OVER;
                        winner_d = 2'b10;
                        timer_d  = OverLoad;
                    end else begin
                        state_d = NEWBALL;
                        timer_d = NewballLoad;
                    end
                end
            end
            NEWBALL: begin
                if (timer_q == 8'd0) begin
                    state_d = PLAY;
                end
            end
            OVER: begin
                if (timer_q == 8'd0) begin
                    state_d  = NEWGAME;
                    score1_d = 4'd0;
                    score2_d = 4'd0;
                    winner_d = 2'b00;
                end
            end
            default: state_d = NEWGAME;
        endcase

        graStill_d = (state_d != PLAY);
    end

    assign bus.gra_still  = graStill_q;
    assign bus.score1     = score1_q;
    assign bus.score2     = score2_q;
    assign bus.winner     = winner_q;
    assign bus.game_state = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed scenarios followed by a
// random phase, every cycle compared against a game-rule reference model.
module tb_pong_game_ctrl;

    localparam int WinPts     = 5;
    localparam int NewballLen = 120;
    localparam int OverLen    = 180;

    logic clk;
    logic rstN;
    int   compared;
    int   mismatched;

    pong_game_ctrl_if dutIf ();

    pong_game_ctrl #(
        .WIN_SCORE    (WinPts),
        .NEWBALL_TICKS(NewballLen),
        .OVER_TICKS   (OverLen)
    ) dut (
        .clk  (clk),
        .reset(rstN),
        .bus  (dutIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model in game terms: phase 0 lobby, 1 rally, 2 waiting for serve, 3 results
    int phase;
    int p1Points;
    int p2Points;
    int champion;
    int framesLeft;
    bit btnWasHigh;

    task automatic modelStep(input bit rst, input bit tick, input bit btn,
                             input bit p1, input bit p2);
        bit pressed;
        if (!rst) begin
            phase = 0; p1Points = 0; p2Points = 0; champion = 0;
            framesLeft = 0; btnWasHigh = 1'b1;
            return;
        end
        pressed    = btn && !btnWasHigh;
        btnWasHigh = btn;
        if (phase == 0) begin
            if (pressed) phase = 1;
        end else if (phase == 1) begin
            if (p1 || p2) begin
                if (p1) p1Points++; else p2Points++;
                if (p1Points == WinPts || p2Points == WinPts) begin
                    champion   = p1 ? 1 : 2;
                    phase      = 3;
                    framesLeft = OverLen;
                end else begin
                    phase      = 2;
                    framesLeft = NewballLen;
                end
            end
        end else if (framesLeft == 0) begin
            if (phase == 3) begin
                p1Points = 0; p2Points = 0; champion = 0;
            end
            phase = (phase == 2) ? 1 : 0;
        end else if (tick) begin
            framesLeft--;
        end
    endtask

    task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic checkOutput();
        checkVal("game_state", {6'd0, dutIf.game_state}, 8'(phase));
        checkVal("gra_still",  {7'd0, dutIf.gra_still},  8'(phase != 1));
        checkVal("score1",     {4'd0, dutIf.score1},     8'(p1Points));
        checkVal("score2",     {4'd0, dutIf.score2},     8'(p2Points));
        checkVal("winner",     {6'd0, dutIf.winner},     8'(champion));
    endtask

    task automatic applyStimulus(input bit rst, input bit tick, input bit btn,
                                 input bit p1, input bit p2);
        rstN               = rst;
        dutIf.refresh_tick = tick;
        dutIf.btn_start    = btn;
        dutIf.pts_1        = p1;
        dutIf.pts_2        = p2;
        @(posedge clk);
        modelStep(rst, tick, btn, p1, p2);
        #1;
        checkOutput();
    endtask

    task automatic tickFrames(input int n, input bit btn);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, btn, 1'b0, 1'b0);
    endtask

    initial begin
        bit btnR, tickR, p1R, p2R, rstR;
        compared   = 0;
        mismatched = 0;
        phase = 0; p1Points = 0; p2Points = 0; champion = 0;
        framesLeft = 0; btnWasHigh = 1'b1;
        rstN = 1'b0;
        dutIf.refresh_tick = 1'b0;
        dutIf.btn_start    = 1'b0;
        dutIf.pts_1        = 1'b0;
        dutIf.pts_2        = 1'b0;
        $display("[TB] starting pong_game_ctrl bench");

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkVal("reset_state", {6'd0, dutIf.game_state}, 8'h00);
        checkVal("reset_still", {7'd0, dutIf.gra_still}, 8'h01);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkVal("start_play", {6'd0, dutIf.game_state}, 8'h01);
        checkVal("start_still", {7'd0, dutIf.gra_still}, 8'h00);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Long point level: one point only; tick on the scoring edge must not count
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 49; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checkVal("hold_pts2_score", {4'd0, dutIf.score2}, 8'h01);
        checkVal("hold_pts2_state", {6'd0, dutIf.game_state}, 8'h02);
        tickFrames(NewballLen, 1'b1);
        checkVal("newball_wait", {6'd0, dutIf.game_state}, 8'h02);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkVal("newball_done", {6'd0, dutIf.game_state}, 8'h01);

        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        checkVal("tie_score1", {4'd0, dutIf.score1}, 8'h01);
        checkVal("tie_score2", {4'd0, dutIf.score2}, 8'h01);

        for (int k = 2; k <= WinPts; k++) begin
            tickFrames(NewballLen + 1, 1'b1);
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        checkVal("win_winner", {6'd0, dutIf.winner}, 8'h01);
        checkVal("win_state", {6'd0, dutIf.game_state}, 8'h03);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkVal("over_ignores_start", {6'd0, dutIf.game_state}, 8'h03);
        tickFrames(OverLen, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkVal("over_done_state", {6'd0, dutIf.game_state}, 8'h00);
        checkVal("over_done_score1", {4'd0, dutIf.score1}, 8'h00);
        checkVal("over_done_winner", {6'd0, dutIf.winner}, 8'h00);

        // Reset mid-countdown, then confirm a full fresh countdown afterwards
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        tickFrames(NewballLen - 60, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkVal("midreset_state", {6'd0, dutIf.game_state}, 8'h00);
        checkVal("midreset_score2", {4'd0, dutIf.score2}, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkVal("held_btn_no_start", {6'd0, dutIf.game_state}, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tickFrames(NewballLen, 1'b1);
        checkVal("reload_wait", {6'd0, dutIf.game_state}, 8'h02);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkVal("reload_done", {6'd0, dutIf.game_state}, 8'h01);

        btnR = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 7) == 0) btnR = ~btnR;
            tickR = ($urandom_range(0, 1) == 1);
            p1R   = ($urandom_range(0, 24) == 0);
            p2R   = ($urandom_range(0, 24) == 0);
            rstR  = ($urandom_range(0, 999) != 0);
            applyStimulus(rstR, tickR, btnR, p1R, p2R);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter: WIN_SCORE, default 5, points that end a game; legal range 1..9.
REQ-002 Parameter: NEWBALL_TICKS, default 120, refresh ticks the block waits between a point and re-serve (2 s at 60 Hz); legal range 1..255.
REQ-003 Parameter: OVER_TICKS, default 180, refresh ticks the game-over screen is held before returning to new-game; legal range 1..255.
REQ-004 Port: clk  input  1  system pixel clock; the only clock in the block.
REQ-005 Port: reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
REQ-006 Port: refresh_tick  input  1  one-clk pulse per frame at start of vertical retrace.
REQ-007 Port: btn_start  input  1  start/serve request, level, already synchronised to clk.
REQ-008 Port: pts_1  input  1  player 1 scored, level from the graphics stage, may stay high for many cycles.
REQ-009 Port: pts_2  input  1  player 2 scored, same behaviour as pts_1.
REQ-010 Port: gra_still  output  1  freezes and recentres the ball in the graphics stage.
REQ-011 Port: score1  output  4  player 1 score, BCD digit 0..9.
REQ-012 Port: score2  output  4  player 2 score, BCD digit 0..9.
REQ-013 Port: winner  output  2  00 = none, 01 = player 1, 10 = player 2; 11 never driven.
REQ-014 Port: game_state  output  2  00 = NEWGAME, 01 = PLAY, 10 = NEWBALL, 11 = OVER, for the text overlay.

Function
REQ-015 Everything except the start-edge detector is a single 4-state FSM (NEWGAME, PLAY, NEWBALL, OVER) plus one 8-bit down-counter timer; all outputs are registered.
REQ-016 The start edge is a rising edge of btn_start, detected against a registered copy of btn_start; a held button produces exactly one edge.
REQ-017 gra_still is 1 in NEWGAME, NEWBALL and OVER, and 0 only in PLAY.
REQ-018 NEWGAME behaviour:
- score1, score2 and winner are held at 0.
- A start edge moves the FSM to PLAY on the next clk.
REQ-019 In PLAY, the FSM acts on pts_1/pts_2 in the first cycle either is high:
- It increments the scoring player's score by 1.
- It leaves PLAY in that same clock edge.
- Later cycles of the same pts level fall outside PLAY and are ignored, so one point is counted per miss.
REQ-020 If pts_1 and pts_2 are high in the same PLAY cycle, pts_1 wins: only score1 increments.
REQ-021 If the incremented score equals WIN_SCORE:
- The next state is OVER.
- winner is set to the scoring player.
- The timer loads OVER_TICKS.
REQ-022 Otherwise the next state is NEWBALL and the timer loads NEWBALL_TICKS.
REQ-023 Timer rules:
- It decrements by 1 only on clk edges where refresh_tick = 1 and the timer is non-zero.
- It never wraps below 0.
REQ-024 NEWBALL moves to PLAY on the clk after the timer reaches 0; btn_start is ignored in NEWBALL.
REQ-025 OVER moves to NEWGAME on the clk after the timer reaches 0; the same edge clears score1, score2 and winner to 0.
REQ-026 A start edge in PLAY or OVER has no effect.
REQ-027 Scores never exceed 9; with WIN_SCORE ≤ 9 the OVER transition happens before any overflow.
REQ-028 refresh_tick arriving in the same cycle as a state entry does not decrement the freshly loaded timer value.

Reset
REQ-029 While reset = 0 at a clk edge, the block sets:
- state = NEWGAME
- score1 = score2 = 0
- winner = 00
- timer = 0
- the registered copy of btn_start = 1, so a button held through reset does not start a game
- gra_still = 1
- game_state = 00
REQ-030 Reset asserted in any state, including mid-countdown, takes effect at the next clk edge and discards the pending timer and scores.
REQ-031 The block has no asynchronous behaviour; reset is ignored between clk edges.

Verification
REQ-032 Reset then btn_start 0→1 → game_state 00→01 one clk later, gra_still 1→0; holding btn_start high produces no further effect.
REQ-033 In PLAY, pts_2 high for 50 cycles → score2 = 1 (not 50), game_state = 10, gra_still = 1; after 120 refresh_tick pulses → game_state = 01.
REQ-034 pts_1 and pts_2 high together in PLAY → score1 = 1, score2 = 0.
REQ-035 Drive 5 points to player 1 (WIN_SCORE = 5) → winner = 01, game_state = 11; after 180 ticks → game_state = 00, scores = 0, winner = 00.
REQ-036 reset = 0 for one clk during NEWBALL with timer = 60 → NEWGAME, scores 0, timer 0; a start edge in OVER is ignored.
